traffic_light_sequencer: RTL and testbench

Six-state intersection controller that sequences the main-street, side-street and walk phases. For each phase it selects an interval code for the time-parameter block and loads that block's registered duration into a down-counter. It then advances the phase on 1 Hz ticks. It sits between the 1 Hz divider and the time-parameter block, and directly drives the lamp outputs.

---
 rtl/traffic_light_sequencer_pkg.sv | 64 ++++++
 rtl/traffic_light_sequencer_if.sv | 11 +
 rtl/traffic_light_sequencer_phase_countdown.sv | 51 +++++
 rtl/traffic_light_sequencer.sv | 110 +++++++++++
 tb/tb_traffic_light_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_sequencer_pkg.sv
// tls_pkg: shared encodings for the traffic light sequencer (states, interval
// codes, lamp patterns) plus small decode helpers used by the top level.
package tls_pkg;

   typedef enum logic [2:0] {
      MAIN_GRN = 3'd0,
      MAIN_YEL = 3'd1,
      WALK     = 3'd2,
      SIDE_GRN = 3'd3,
      SIDE_EXT = 3'd4,
      SIDE_YEL = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      LOAD0 = 2'd0,
      LOAD1 = 2'd1,
      COUNT = 2'd2
   } phase_t;

   localparam logic [1:0] INT_BASE = 2'b00;
   localparam logic [1:0] INT_EXT  = 2'b01;
   localparam logic [1:0] INT_YEL  = 2'b10;
   localparam logic [1:0] INT_DBL  = 2'b11;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   // Main-street lamp pattern shown while in a given state
   function automatic logic [2:0] main_lamp(input state_t s);
      logic [2:0] r;
      case (s)
         MAIN_GRN: r = LAMP_G;
         MAIN_YEL: r = LAMP_Y;
         default:  r = LAMP_R;
      endcase
      return r;
   endfunction

   // Side-street lamp pattern shown while in a given state
   function automatic logic [2:0] side_lamp(input state_t s);
      logic [2:0] r;
      case (s)
         SIDE_GRN, SIDE_EXT: r = LAMP_G;
         SIDE_YEL:           r = LAMP_Y;
         default:            r = LAMP_R;
      endcase
      return r;
   endfunction

   // Interval code requested when a state is entered; main green stretches
   // to double base when no side-street car is waiting
   function automatic logic [1:0] interval_code(input state_t s, input logic sensor);
      logic [1:0] r;
      case (s)
         MAIN_GRN:           r = sensor ? INT_BASE : INT_DBL;
         MAIN_YEL, SIDE_YEL: r = INT_YEL;
         WALK, SIDE_EXT:     r = INT_EXT;
         default:            r = INT_BASE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// traffic_light_sequencer_if: link between the sequencer (master) and the
// time-parameter block (slave): interval code out, registered duration back.
interface traffic_light_sequencer_if;
   import tls_pkg::*;

   logic [1:0] interval;
   logic [3:0] value;

   modport master (output interval, input value);
   modport slave  (input interval, output value);
endinterface

// File: rtl/traffic_light_sequencer_phase_countdown.sv
// phase_countdown: two load cycles (wait for the parameter block to register
// the duration) followed by a 4-bit tick countdown. A zero duration is forced
// to one so every phase lasts at least one tick.
module phase_countdown
   import tls_pkg::*;
(
   input  logic       clk,
   input  logic       Reset_n,
   input  logic       start,
   input  logic       Tick,
   input  logic [3:0] value,
   output logic       expired
);

   phase_t     phase;
   phase_t     phase_next;
   logic [3:0] count;

   assign expired = (phase == COUNT) && Tick && (count == 4'd1);

   // Step through LOAD0 -> LOAD1 -> COUNT, restarting whenever a new phase opens
   always_comb begin
      phase_next = phase;
      if (start) begin
         phase_next = LOAD0;
      end else begin
         case (phase)
            LOAD0:   phase_next = LOAD1;
            LOAD1:   phase_next = COUNT;
            COUNT:   phase_next = COUNT;
            default: phase_next = LOAD0;
         endcase
      end
   end

   // Phase register plus counter: load on leaving LOAD1, decrement on ticks
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         phase <= LOAD0;
         count <= 4'd0;
      end else begin
         phase <= phase_next;
         if (!start && (phase == LOAD1)) begin
            count <= (value == 4'd0) ? 4'd1 : value;
         end else if (!start && (phase == COUNT) && Tick) begin
            count <= count - 4'd1;
         end
      end
   end

endmodule

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: six-state intersection controller. Each state entry
// requests an interval from the time-parameter block and waits out the
// returned duration in 1 Hz ticks. Optional pedestrian phase: TLS_WALK_EN.
module traffic_light_sequencer
   import tls_pkg::*;
(
   input  logic                             clk,
   input  logic                             Reset_n,
   input  logic                             Tick,
   input  logic                             Sensor,
   input  logic                             Walk_Request,
   input  logic                             Prog_Sync,
   traffic_light_sequencer_if.master        tp,
   output logic [2:0]                       Main_Lights,
   output logic [2:0]                       Side_Lights,
   output logic                             Walk_Lamp
);

   state_t state;
   state_t state_next;
   logic   expired;
   logic   start;

   assign start = expired | Prog_Sync;

   phase_countdown u_countdown (
      .clk     (clk),
      .Reset_n (Reset_n),
      .start   (start),
      .Tick    (Tick),
      .value   (tp.value),
      .expired (expired)
   );

`ifdef TLS_WALK_EN
   logic walk_latch;
   logic walk_pend;
   logic walk_exit;

   assign walk_exit = (state == WALK) && expired && !Prog_Sync;

   // Remember pedestrian requests; ones arriving during WALK wait for the next round
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         walk_latch <= 1'b0;
         walk_pend  <= 1'b0;
      end else if (walk_exit) begin
         walk_latch <= walk_pend | Walk_Request;
         walk_pend  <= 1'b0;
      end else begin
         walk_latch <= walk_latch | Walk_Request;
         walk_pend  <= (state == WALK) & (walk_pend | Walk_Request);
      end
   end

   // Walk indicator follows the registered state
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Walk_Lamp <= 1'b0;
      end else begin
         Walk_Lamp <= (state_next == WALK);
      end
   end
`else
   logic unused_walk_request;
   assign unused_walk_request = Walk_Request;
   assign Walk_Lamp = 1'b0;
`endif

   // Next phase: reprogramming wins, otherwise advance only on expiry
   always_comb begin
      state_next = state;
      if (Prog_Sync) begin
         state_next = MAIN_GRN;
      end else if (expired) begin
         case (state)
            MAIN_GRN: state_next = MAIN_YEL;
`ifdef TLS_WALK_EN
            MAIN_YEL: state_next = walk_latch ? WALK : SIDE_GRN;
            WALK:     state_next = SIDE_GRN;
`else
            MAIN_YEL: state_next = SIDE_GRN;
`endif
            SIDE_GRN: state_next = Sensor ? SIDE_EXT : SIDE_YEL;
            SIDE_EXT: state_next = SIDE_YEL;
            SIDE_YEL: state_next = MAIN_GRN;
            default:  state_next = MAIN_GRN;
         endcase
      end
   end

   // State register with registered lamp and interval outputs; the interval
   // is only resampled when a phase opens so Sensor cannot change it mid-phase
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= MAIN_GRN;
         tp.interval <= INT_DBL;
         Main_Lights <= LAMP_G;
         Side_Lights <= LAMP_R;
      end else begin
         state       <= state_next;
         Main_Lights <= main_lamp(state_next);
         Side_Lights <= side_lamp(state_next);
         if (start) begin
            tp.interval <= interval_code(state_next, Sensor);
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb_traffic_light_sequencer: drives the sequencer with a stand-in
// time-parameter block (base 6, ext 3, yel 2, double 12), compares every cycle
// against a phase-level model and pins phase lengths with literal values.
module tb_traffic_light_sequencer;

   logic       clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic       Tick = 1'b1;
   logic       Sensor = 1'b0;
   logic       Walk_Request = 1'b0;
   logic       Prog_Sync = 1'b0;
   logic [2:0] Main_Lights;
   logic [2:0] Side_Lights;
   logic       Walk_Lamp;

   traffic_light_sequencer_if tp();

   int checkCount = 0;
   int errorCount = 0;
   bit compareOn = 1'b0;

   logic [3:0] baseVal = 4'd6;
   logic [3:0] extVal  = 4'd3;
   logic [3:0] yelVal  = 4'd2;
   logic [3:0] dblVal  = 4'd12;

`ifdef TLS_WALK_EN
   localparam bit walkBuilt = 1'b1;
`else
   localparam bit walkBuilt = 1'b0;
`endif

   localparam int S_MG = 0;
   localparam int S_MY = 1;
   localparam int S_WK = 2;
   localparam int S_SG = 3;
   localparam int S_SE = 4;
   localparam int S_SY = 5;

   logic [2:0] mainOf [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   logic [2:0] sideOf [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
   logic       walkOf [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   int         mState;
   int         mAge;
   int         mTicks;
   int         mDur;
   logic [1:0] mInt;
   bit         mLatch;
   bit         mPend;

   traffic_light_sequencer dut (
      .clk          (clk),
      .Reset_n      (Reset_n),
      .Tick         (Tick),
      .Sensor       (Sensor),
      .Walk_Request (Walk_Request),
      .Prog_Sync    (Prog_Sync),
      .tp           (tp),
      .Main_Lights  (Main_Lights),
      .Side_Lights  (Side_Lights),
      .Walk_Lamp    (Walk_Lamp)
   );

   always #5 clk = ~clk;

   // Stand-in for the time-parameter block: registers the duration for the requested interval
   always @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tp.value <= 4'd0;
      end else begin
         case (tp.interval)
            2'b00:   tp.value <= baseVal;
            2'b01:   tp.value <= extVal;
            2'b10:   tp.value <= yelVal;
            default: tp.value <= dblVal;
         endcase
      end
   end

   function automatic int durOf(input logic [1:0] code);
      logic [3:0] v;
      case (code)
         2'b00:   v = baseVal;
         2'b01:   v = extVal;
         2'b10:   v = yelVal;
         default: v = dblVal;
      endcase
      return (v == 4'd0) ? 1 : int'(v);
   endfunction

   function automatic logic [1:0] intervalOn(input int s, input logic sensor);
      logic [1:0] r;
      case (s)
         S_MG:       r = sensor ? 2'b00 : 2'b11;
         S_MY, S_SY: r = 2'b10;
         S_WK, S_SE: r = 2'b01;
         default:    r = 2'b00;
      endcase
      return r;
   endfunction

   // Phase-level model: a phase is two load cycles plus its duration in ticks
   always @(posedge clk or negedge Reset_n) begin : model
      int         nState;
      int         nAge;
      int         nTicks;
      int         nDur;
      logic [1:0] nInt;
      bit         nLatch;
      bit         nPend;
      bit         expire;
      bit         req;
      if (!Reset_n) begin
         mState <= S_MG;
         mInt   <= 2'b11;
         mAge   <= 0;
         mTicks <= 0;
         mDur   <= durOf(2'b11);
         mLatch <= 1'b0;
         mPend  <= 1'b0;
      end else begin
         req    = walkBuilt && Walk_Request;
         expire = (mAge >= 2) && Tick && (mTicks + 1 == mDur);
         nState = mState;
         nAge   = mAge + 1;
         nTicks = mTicks + (((mAge >= 2) && Tick) ? 1 : 0);
         nInt   = mInt;
         nDur   = mDur;
         nLatch = mLatch | req;
         nPend  = 1'b0;
         if (mState == S_WK) begin
            if (expire && !Prog_Sync) begin
               nLatch = mPend | req;
               nPend  = 1'b0;
            end else begin
               nPend = mPend | req;
            end
         end
         if (Prog_Sync) begin
            nState = S_MG;
         end else if (expire) begin
            case (mState)
               S_MG:    nState = S_MY;
               S_MY:    nState = (walkBuilt && mLatch) ? S_WK : S_SG;
               S_WK:    nState = S_SG;
               S_SG:    nState = Sensor ? S_SE : S_SY;
               S_SE:    nState = S_SY;
               default: nState = S_MG;
            endcase
         end
         if (Prog_Sync || expire) begin
            nAge   = 0;
            nTicks = 0;
            nInt   = intervalOn(nState, Sensor);
            nDur   = durOf(nInt);
         end
         mState <= nState;
         mAge   <= nAge;
         mTicks <= nTicks;
         mInt   <= nInt;
         mDur   <= nDur;
         mLatch <= nLatch;
         mPend  <= nPend;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic sensor, input logic walkReq, input logic progSync);
      Sensor       = sensor;
      Walk_Request = walkReq;
      Prog_Sync    = progSync;
   endtask

   // Counts cycles (one sample per negedge) that the current output pattern persists
   task automatic measurePhase(input string name, input int expLen);
      logic [8:0] sig;
      int         n;
      sig = {Main_Lights, Side_Lights, Walk_Lamp, tp.interval};
      n = 1;
      while (n < 100) begin
         @(negedge clk);
         if ({Main_Lights, Side_Lights, Walk_Lamp, tp.interval} !== sig) break;
         n++;
      end
      checkOutput(name, n, expLen);
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("main lamps", Main_Lights, mainOf[mState]);
         checkOutput("side lamps", Side_Lights, sideOf[mState]);
         checkOutput("walk lamp", Walk_Lamp, walkOf[mState]);
         checkOutput("interval", tp.interval, mInt);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 Reset_n = 1'b0;
      #1 compareOn = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset interval", tp.interval, 2'b11);
      checkOutput("reset main", Main_Lights, 3'b001);
      checkOutput("reset side", Side_Lights, 3'b100);
      checkOutput("reset walk", Walk_Lamp, 1'b0);
      Reset_n = 1'b1;

      // Plain cycle, no side traffic
      measurePhase("main grn dbl", 14);
      measurePhase("main yel", 4);
      measurePhase("side grn", 8);
      applyStimulus(1'b1, 1'b0, 1'b0);
      measurePhase("side yel", 4);

      // Side traffic present throughout
      checkOutput("main grn base interval", tp.interval, 2'b00);
      measurePhase("main grn base", 8);
      measurePhase("main yel s", 4);
      measurePhase("side grn s", 8);
      checkOutput("side ext interval", tp.interval, 2'b01);
      measurePhase("side ext", 5);
      applyStimulus(1'b0, 1'b0, 1'b0);
      measurePhase("side yel s", 4);

      // Pedestrian request during main green
      checkOutput("main grn dbl interval", tp.interval, 2'b11);
      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      measurePhase("main grn walk", 13);
      measurePhase("main yel walk", 4);
`ifdef TLS_WALK_EN
      checkOutput("walk lamp on", Walk_Lamp, 1'b1);
      checkOutput("walk main red", Main_Lights, 3'b100);
      checkOutput("walk side red", Side_Lights, 3'b100);
      measurePhase("walk", 5);
`endif
      measurePhase("side grn walk", 8);
      measurePhase("side yel walk", 4);
      measurePhase("main grn after walk", 14);
      measurePhase("main yel after walk", 4);
      checkOutput("latch cleared", Side_Lights, 3'b001);
      measurePhase("side grn after walk", 8);
      measurePhase("side yel after walk", 4);

      // Zero yellow duration still lasts one tick
      yelVal = 4'd0;
      measurePhase("main grn zero yel", 14);
      measurePhase("main yel zero", 3);
      yelVal = 4'd2;
      measurePhase("side grn restore", 8);

      // Reprogram strobe during side yellow
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("sync interval", tp.interval, 2'b11);
      checkOutput("sync main", Main_Lights, 3'b001);
      checkOutput("sync side", Side_Lights, 3'b100);
      measurePhase("main grn after sync", 14);
      measurePhase("main yel after sync", 4);

      // Asynchronous reset in the middle of side green
      @(negedge clk);
      #2 Reset_n = 1'b0;
      #1;
      checkOutput("async reset main", Main_Lights, 3'b001);
      checkOutput("async reset side", Side_Lights, 3'b100);
      checkOutput("async reset interval", tp.interval, 2'b11);
      checkOutput("async reset walk", Walk_Lamp, 1'b0);
      @(negedge clk);
      Reset_n = 1'b1;
      measurePhase("main grn after reset", 14);
      measurePhase("main yel after reset", 4);

      compareOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
